uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO plus issue controller that sits directly upstream of the uart core's transmit side.
- Accepts bytes from on-chip logic through a push interface.
- Pops one byte at a time and drives the core's transmit/tx_byte inputs, pacing on is_transmitting.
- Removes the need for producers to poll transmitter busy state.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 bytes.
- BUSY_TIMEOUT, 8, cycles to wait in WAIT_BUSY for is_transmitting to rise before returning to IDLE; range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  push request; sampled every cycle.
- wr_data  input  8  byte to push.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- count  output  DEPTH_LOG2+1  bytes currently stored.
- overflow  output  1  sticky flag, set on push while full.
- clr_overflow  input  1  clears overflow.
- transmit  output  1  one-cycle pulse to the uart core.
- tx_byte  output  8  byte presented to the uart core with transmit.
- is_transmitting  input  1  uart core busy indication.

Behaviour:
- Reset:
  - Applies on rising clk while rst = 1.
  - Clears rd_ptr, wr_ptr, count and overflow; transmit = 0; tx_byte = 8'h00; state = IDLE.
  - empty = 1, full = 0.
  - Reset mid-transfer abandons the FIFO contents. The byte already handed to the core is not recalled.
- Storage:
  - Circular buffer of depth entries with DEPTH_LOG2-bit rd/wr pointers that wrap naturally.
  - count is a separate register. full and empty are derived combinationally from the registered count.
- Push:
  - When wr_en = 1 and full = 0: mem[wr_ptr] <= wr_data, wr_ptr++.
  - When wr_en = 1 and full = 1: data dropped, pointers unchanged, overflow <= 1.
  - A push while full is rejected even if a pop occurs in the same cycle, because full is evaluated on the pre-edge count.
- Overflow:
  - clr_overflow = 1 clears overflow.
  - If a rejected push and clr_overflow occur in the same cycle, set wins and overflow stays 1.
- Pop:
  - Occurs only on the IDLE->WAIT_BUSY transition: rd_ptr++.
- Count update per edge:
  - +1 on accepted push, -1 on pop, unchanged when both occur.
  - A simultaneous accepted push and pop is legal whenever 0 < count < depth.
- FSM, 3 states, registered outputs:
  - IDLE:
    - transmit <= 0.
    - If empty = 0 and is_transmitting = 0: tx_byte <= mem[rd_ptr], transmit <= 1, pop, timer <= 0, go to WAIT_BUSY.
    - Otherwise stay in IDLE.
  - WAIT_BUSY:
    - transmit <= 0, timer++.
    - If is_transmitting = 1: go to WAIT_DONE.
    - Else if timer == BUSY_TIMEOUT-1: go to IDLE (covers a core that completes or ignores the request quickly).
  - WAIT_DONE:
    - transmit <= 0.
    - When is_transmitting = 0: go to IDLE.
- transmit:
  - High for exactly one cycle per popped byte.
  - Never high on two consecutive cycles.
- tx_byte:
  - Updates only together with transmit.
  - Holds its value otherwise.
- Latency:
  - Push accepted at edge N into an empty FIFO, with FSM in IDLE and is_transmitting = 0 → transmit = 1 after edge N+1.
  - The same edge N+1 decrements count back to 0.
- Back-to-back throughput: minimum spacing between transmit pulses is 3 cycles (IDLE → WAIT_BUSY → WAIT_DONE → IDLE) plus the core's busy time.
- Ordering: bytes are issued strictly in push order. No byte is duplicated or skipped except pushes rejected while full.

Test Plan:
- Single byte: reset, push 8'hA5 with is_transmitting model idle → transmit pulses 1 cycle two edges later with tx_byte = 8'hA5; count returns to 0; empty = 1.
- Burst order: push 8'h01..8'h10 back-to-back (16 bytes); core model asserts busy for 20 cycles after each transmit → 16 transmit pulses with tx_byte 8'h01..8'h10 in order; no pulse while is_transmitting = 1.
- Full/overflow: hold is_transmitting = 1, push 17 bytes → full = 1 after the 16th push, count = 16, overflow = 1 after the 17th. Then pulse clr_overflow → overflow = 0. Then release busy → exactly 16 bytes issued.
- Simultaneous push/pop: with count = 3, push on the same cycle the FSM pops → count stays 3; data order is preserved.
- Timeout: core model never raises is_transmitting → FSM returns to IDLE after BUSY_TIMEOUT = 8 cycles and issues the next byte; count decrements by 1 per issue.
- Reset mid-operation: assert rst while in WAIT_DONE with count = 5 → next cycle count = 0, empty = 1, transmit = 0, tx_byte = 8'h00, overflow = 0; no further transmit pulse until a new push.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Push/status/transmit bundle between byte producers, the TX FIFO and the uart core.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  clr_overflow;
  logic                  transmit;
  logic [7:0]            tx_byte;
  logic                  is_transmitting;

  // Surrounding system: producer plus uart core
  modport master (
    output wr_en, wr_data, clr_overflow, is_transmitting,
    input  full, empty, count, overflow, transmit, tx_byte
  );

  // The FIFO/issue controller
  modport slave (
    input  wr_en, wr_data, clr_overflow, is_transmitting,
    output full, empty, count, overflow, transmit, tx_byte
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue controller feeding the uart core's transmit side.
// Bytes are popped one at a time and handed to the core with a single-cycle
// transmit pulse, pacing on the core's is_transmitting indication.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;
  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               transmit_q;
  logic [7:0]         tx_byte_q;

  logic               full_c;
  logic               empty_c;
  logic               push_ok_c;
  logic               push_rej_c;
  logic               pop_c;

  // Status flags come straight from the registered count; push/pop qualifiers use pre-edge state
  always_comb begin
    full_c     = (count_q == CNT_W'(DEPTH));
    empty_c    = (count_q == '0);
    push_ok_c  = bus.wr_en && !full_c;
    push_rej_c = bus.wr_en && full_c;
    pop_c      = (state == IDLE) && !empty_c && !bus.is_transmitting;
  end

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.transmit = transmit_q;
  assign bus.tx_byte  = tx_byte_q;

  // Storage array; contents are abandoned on reset, so no reset is needed here
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the array depth
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a rejected push beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_rej_c) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // Issue controller: hand one byte to the core, then wait for it to go busy and idle again
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      transmit_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_c) begin
            tx_byte_q  <= mem[rd_ptr];
            transmit_q <= 1'b1;
            timer      <= '0;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          timer <= timer + TIMER_W'(1);
          if (bus.is_transmitting) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_W'(BUSY_TIMEOUT - 1)) begin
            // Core finished or ignored the request before we saw it go busy
            state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!bus.is_transmitting) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2   = 4;
  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 8;

  localparam int CORE_RESP  = 0;
  localparam int CORE_NEVER = 1;
  localparam int CORE_HOLD  = 2;
  localparam int CORE_RAND  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  // Reference model state
  byte unsigned mq[$];
  bit           m_over    = 1'b0;
  bit           m_tx      = 1'b0;
  byte unsigned m_byte    = 8'h00;
  bit           m_waiting = 1'b0;
  bit           m_saw_busy = 1'b0;
  int           m_waited  = 0;

  // Core model and transmit log
  int           core_mode = CORE_NEVER;
  int           busy_len  = 0;
  int           busy_left = 0;
  logic [7:0]   txq[$];
  int           tx_times[$];
  int           cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock edge of the reference: FIFO as a queue, controller as "busy until released"
  task automatic model_step();
    byte unsigned popped;
    bit issue;
    bit full_pre;
    popped = 8'h00;
    if (rst) begin
      mq.delete();
      m_over = 1'b0; m_tx = 1'b0; m_byte = 8'h00;
      m_waiting = 1'b0; m_saw_busy = 1'b0; m_waited = 0;
      return;
    end
    full_pre = (mq.size() == DEPTH);
    issue = !m_waiting && (mq.size() > 0) && !bus.is_transmitting;
    if (issue) popped = mq.pop_front();
    if (bus.wr_en && !full_pre) mq.push_back(bus.wr_data);
    if (bus.wr_en && full_pre) m_over = 1'b1;
    else if (bus.clr_overflow) m_over = 1'b0;
    if (issue) begin
      m_waiting = 1'b1; m_saw_busy = 1'b0; m_waited = 0;
    end else if (m_waiting) begin
      if (m_saw_busy) begin
        if (!bus.is_transmitting) m_waiting = 1'b0;
      end else if (bus.is_transmitting) begin
        m_saw_busy = 1'b1;
      end else begin
        m_waited++;
        if (m_waited == BUSY_TIMEOUT) m_waiting = 1'b0;
      end
    end
    m_tx = issue;
    if (issue) m_byte = popped;
  endtask

  // Per-cycle compare of every output against the model
  always @(posedge clk) begin
    model_step();
    #1;
    if (check_en) begin
      check("transmit", int'(bus.transmit), int'(m_tx));
      check("tx_byte",  int'(bus.tx_byte),  int'(m_byte));
      check("count",    int'(bus.count),    mq.size());
      check("full",     int'(bus.full),     int'(mq.size() == DEPTH));
      check("empty",    int'(bus.empty),    int'(mq.size() == 0));
      check("overflow", int'(bus.overflow), int'(m_over));
    end
  end

  task automatic core_update();
    case (core_mode)
      CORE_RESP: begin
        if (bus.transmit) busy_left = busy_len;
        bus.is_transmitting = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      CORE_NEVER: begin
        busy_left = 0;
        bus.is_transmitting = 1'b0;
      end
      CORE_HOLD: bus.is_transmitting = 1'b1;
      default: begin
        if (bus.transmit && ($urandom_range(0, 1) == 1)) busy_left = int'($urandom_range(1, 12));
        bus.is_transmitting = (busy_left > 0) || ($urandom_range(0, 15) == 0);
        if (busy_left > 0) busy_left--;
      end
    endcase
  endtask

  // Advance one edge; inputs change and outputs are observed on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.transmit) begin
      txq.push_back(bus.tx_byte);
      tx_times.push_back(cyc);
    end
    core_update();
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain_and_settle(input string name, input int limit);
    for (int i = 0; i < limit && !bus.empty; i++) tick();
    check(name, int'(bus.empty), 1);
    repeat (40) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_overflow = 1'b0;
    bus.is_transmitting = 1'b0;
    check_en = 1'b1;
    tick();
    tick();
    check("rst_count",    int'(bus.count), 0);
    check("rst_empty",    int'(bus.empty), 1);
    check("rst_full",     int'(bus.full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_transmit", int'(bus.transmit), 0);
    check("rst_tx_byte",  int'(bus.tx_byte), 0);
    rst = 1'b0;
    tick();

    // Single byte: push lands at edge N, issue at edge N+1
    core_mode = CORE_RESP; busy_len = 3;
    push(8'hA5);
    check("single_count_after_push", int'(bus.count), 1);
    check("single_no_early_tx", int'(bus.transmit), 0);
    tick();
    check("single_transmit", int'(bus.transmit), 1);
    check("single_tx_byte", int'(bus.tx_byte), 8'hA5);
    check("single_count_zero", int'(bus.count), 0);
    check("single_empty", int'(bus.empty), 1);
    tick();
    check("single_pulse_width", int'(bus.transmit), 0);
    check("single_byte_held", int'(bus.tx_byte), 8'hA5);
    drain_and_settle("single_drain", 100);

    // Burst of 16 with a 20-cycle busy core
    core_mode = CORE_RESP; busy_len = 20;
    txq.delete();
    for (int i = 1; i <= 16; i++) push(8'(i));
    drain_and_settle("burst_drain", 1000);
    check("burst_n", txq.size(), 16);
    for (int i = 0; i < txq.size() && i < 16; i++) check("burst_byte", int'(txq[i]), i + 1);

    // Full and overflow with the core held busy
    core_mode = CORE_HOLD;
    bus.is_transmitting = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(8'h30 + 8'(i));
      if (i == 15) begin
        check("full_at_16", int'(bus.full), 1);
        check("count_at_16", int'(bus.count), 16);
        check("no_overflow_at_16", int'(bus.overflow), 0);
      end
    end
    check("overflow_at_17", int'(bus.overflow), 1);
    check("count_stays_16", int'(bus.count), 16);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.clr_overflow = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("overflow_set_wins", int'(bus.overflow), 1);
    tick();
    bus.clr_overflow = 1'b0;
    check("overflow_cleared", int'(bus.overflow), 0);
    txq.delete();
    core_mode = CORE_RESP; busy_len = 2;
    drain_and_settle("full_drain", 1000);
    check("full_issued_n", txq.size(), 16);
    for (int i = 0; i < txq.size() && i < 16; i++) check("full_byte", int'(txq[i]), 8'h30 + i);

    // Simultaneous push and pop at count 3, then timeout pacing
    core_mode = CORE_HOLD;
    bus.is_transmitting = 1'b1;
    push(8'h61); push(8'h62); push(8'h63);
    check("simul_count_pre", int'(bus.count), 3);
    txq.delete(); tx_times.delete();
    core_mode = CORE_NEVER;
    bus.is_transmitting = 1'b0;
    push(8'h64);
    check("simul_count_held", int'(bus.count), 3);
    check("simul_transmit", int'(bus.transmit), 1);
    check("simul_byte", int'(bus.tx_byte), 8'h61);
    drain_and_settle("timeout_drain", 200);
    check("timeout_n", txq.size(), 4);
    for (int i = 0; i < txq.size() && i < 4; i++) check("timeout_byte", int'(txq[i]), 8'h61 + i);
    for (int i = 0; i + 1 < tx_times.size() && i < 3; i++)
      check("timeout_spacing", tx_times[i+1] - tx_times[i], BUSY_TIMEOUT + 1);

    // Reset while waiting for the core to finish, five bytes queued
    core_mode = CORE_RESP; busy_len = 40;
    for (int i = 0; i < 6; i++) push(8'h71 + 8'(i));
    check("midrst_count_pre", int'(bus.count), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", int'(bus.count), 0);
    check("midrst_empty", int'(bus.empty), 1);
    check("midrst_transmit", int'(bus.transmit), 0);
    check("midrst_tx_byte", int'(bus.tx_byte), 0);
    check("midrst_overflow", int'(bus.overflow), 0);
    txq.delete();
    core_mode = CORE_NEVER;
    repeat (30) tick();
    check("midrst_no_tx", txq.size(), 0);

    // Random traffic: heavy then light push rate, random core and clears
    core_mode = CORE_RAND;
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      bus.wr_data = 8'($urandom_range(0, 255));
      bus.clr_overflow = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.clr_overflow = 1'b0;
    rst = 1'b0;
    drain_and_settle("rand_drain", 2000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
